// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b.sv
// Programmable clock divider, ratio DIV+2 (2..17), with graceful stop.
// Z, TC and BUSY are all flop outputs so the divided clock is glitch-free.
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [3:0] DIV,
    output logic       Z,
    output logic       TC,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] nact_q, nact_d;
    logic [4:0] h_q, h_d;
    logic       z_q, z_d;
    logic       tc_q, tc_d;
    logic       busy_q, busy_d;

    logic [4:0] div_n;
    logic [4:0] div_n_inc;
    logic [4:0] div_h;
    logic       wrap;

    assign div_n     = {1'b0, DIV} + 5'd2;
    assign div_n_inc = div_n + 5'd1;
    assign div_h     = {1'b0, div_n_inc[4:1]};
    assign wrap      = (cnt_q == (nact_q - 5'd1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nact_d  = nact_q;
        h_d     = h_q;

        case (state_q)
            StIdle: begin
                cnt_d = 5'd0;
                if (EN) begin
                    state_d = StRun;
                    nact_d  = div_n;
                    h_d     = div_h;
                end
            end
            StRun, StStop: begin
                if (wrap) begin
                    cnt_d = 5'd0;
                    // DIV is only picked up here, so a period is never cut short.
                    if (EN) begin
                        state_d = StRun;
                        nact_d  = div_n;
                        h_d     = div_h;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                    state_d = EN ? StRun : StStop;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 5'd0;
            end
        endcase

        if (RST) begin
            state_d = StIdle;
            cnt_d   = 5'd0;
            nact_d  = 5'd2;
            h_d     = 5'd1;
        end

        // Outputs are derived from next state so they land in flops.
        busy_d = (state_d != StIdle);
        z_d    = busy_d && (cnt_d < h_d);
        tc_d   = busy_d && (cnt_d == (nact_d - 5'd1));
    end

    always_ff @(posedge CLK) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        nact_q  <= nact_d;
        h_q     <= h_d;
        z_q     <= z_d;
        tc_q    <= tc_d;
        busy_q  <= busy_d;
    end

    assign Z    = z_q;
    assign TC   = tc_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b.sv
// Bench for the 4-bit clock divider: directed scenarios plus random traffic,
// compared every cycle against a period-position model.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] div;
    logic       z;
    logic       tc;
    logic       busy;

    int checks;
    int errors;

    // Model: whether a period is in progress, position within it, its length.
    bit m_active;
    int m_pos;
    int m_n;

    gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b dut (
        .CLK  (clk),
        .RST  (rst),
        .EN   (en),
        .DIV  (div),
        .Z    (z),
        .TC   (tc),
        .BUSY (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input bit r, input bit e, input int d);
        if (r) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_n      = 2;
        end else if (!m_active) begin
            if (e) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_n      = d + 2;
            end
        end else if (m_pos == m_n - 1) begin
            m_pos = 0;
            if (e) m_n = d + 2;
            else   m_active = 1'b0;
        end else begin
            m_pos = m_pos + 1;
        end
    endtask

    task automatic step(input bit r, input bit e, input int d, input string tag);
        bit exp_z;
        bit exp_tc;
        bit exp_busy;
        @(negedge clk);
        rst = r;
        en  = e;
        div = 4'(d);
        @(posedge clk);
        model_edge(r, e, d);
        #1;
        exp_busy = m_active;
        exp_z    = m_active && (m_pos < (m_n + 1) / 2);
        exp_tc   = m_active && (m_pos == m_n - 1);
        checks++;
        assert (z === exp_z) else begin
            errors++;
            $error("FAIL %s Z: observed %b expected %b (pos %0d n %0d)", tag, z, exp_z, m_pos, m_n);
        end
        checks++;
        assert (tc === exp_tc) else begin
            errors++;
            $error("FAIL %s TC: observed %b expected %b (pos %0d n %0d)", tag, tc, exp_tc,
                   m_pos, m_n);
        end
        checks++;
        assert (busy === exp_busy) else begin
            errors++;
            $error("FAIL %s BUSY: observed %b expected %b", tag, busy, exp_busy);
        end
    endtask

    initial begin
        int d;
        bit r;
        bit e;
        checks   = 0;
        errors   = 0;
        m_active = 1'b0;
        m_pos    = 0;
        m_n      = 2;
        rst      = 1'b1;
        en       = 1'b0;
        div      = 4'd0;

        // Reset held with EN high: outputs stay at reset values.
        repeat (3) step(1, 1, 5, "reset");

        // DIV=2: Z 1,1,0,0 with TC every fourth cycle.
        repeat (20) step(0, 1, 2, "div2");
        repeat (6) step(0, 0, 2, "div2_stop");

        // DIV=1: period 3, Z 1,1,0.
        repeat (12) step(0, 1, 1, "div1");
        repeat (4) step(0, 0, 1, "div1_stop");

        // Minimum and maximum ratio.
        repeat (10) step(0, 1, 0, "div0");
        repeat (40) step(0, 1, 15, "div15");
        repeat (20) step(0, 0, 15, "div15_stop");

        // DIV 6 -> 0 at cnt=2: current period must finish as 4 high, 4 low.
        repeat (3) step(0, 1, 6, "chg_pre");
        repeat (12) step(0, 1, 0, "chg_post");
        repeat (3) step(0, 0, 0, "chg_stop");

        // N=8, EN dropped while cnt=1: period completes, then idle.
        repeat (2) step(0, 1, 6, "drop_pre");
        repeat (10) step(0, 0, 6, "drop_post");

        // N=8, EN low for one edge at cnt=5, back at cnt=6: no gap.
        repeat (6) step(0, 1, 6, "bounce_pre");
        step(0, 0, 6, "bounce_low");
        repeat (12) step(0, 1, 6, "bounce_post");
        repeat (9) step(0, 0, 6, "bounce_stop");

        // N=5, RST pulsed at cnt=2 with EN held high.
        repeat (3) step(0, 1, 3, "rst_pre");
        step(1, 1, 3, "rst_pulse");
        repeat (8) step(0, 1, 3, "rst_post");

        // Random traffic, including mid-period resets and DIV changes.
        d = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) d = int'($urandom_range(0, 15));
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 5) != 0);
            step(r, e, d, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b.md
GF180MCU_FD_SC_MCU9T5V0__CLKDIV_4B -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__clkdiv_4b

Interface
REQ-001 SHALL use one clock, CLK; all flops SHALL be rising-edge CLK; reset is synchronous and active-high.
REQ-002 Ports SHALL be, one per line (name direction width meaning):
 CLK  input  1  source clock
 RST  input  1  synchronous active-high reset
 EN   input  1  divider run request, level-sensitive
 DIV  input  4  divide code; ratio N = DIV+2 (2..17)
 Z    output 1  divided clock; registered; drives the downstream clkinv tree
 TC   output 1  terminal-count pulse, high during the last CLK cycle of each Z period
 BUSY output 1  high while the divider is in RUN or STOP
REQ-003 Parameters: none; width of DIV SHALL be fixed at 4.

Function
REQ-004 Z, TC and BUSY SHALL each come directly from a flop; no output SHALL be combinational, so Z is glitch-free.
REQ-005 The FSM SHALL have three states: IDLE, RUN and STOP.
REQ-006 IDLE: Z=0, TC=0, BUSY=0, and the counter is held at 0.
REQ-007 IDLE->RUN on the edge where EN=1 is sampled; on that edge the block SHALL latch Nact=DIV+2 and H=ceil(Nact/2), and Z SHALL become 1 immediately after that edge.
REQ-008 RUN: the 5-bit counter cnt SHALL step 0..Nact-1 and wrap to 0; Z SHALL be 1 for the H CLK cycles with cnt<H and 0 for the Nact-H cycles that follow.
REQ-009 Duty: N even gives exactly 50%; N odd gives one extra high cycle (for example N=3 is 2 high and 1 low).
REQ-010 TC SHALL be 1 exactly in the cycle where cnt=Nact-1, so one TC pulse occurs per period.
REQ-011 DIV SHALL be re-sampled only on the wrap edge (cnt=Nact-1 -> 0); any DIV change mid-period SHALL NOT affect the current period, so no runt pulse is produced.
REQ-012 RUN->STOP on the edge where EN=0 is sampled and cnt is not equal to Nact-1; STOP SHALL finish the current period unchanged, including TC.
REQ-013 RUN->IDLE directly on the edge where EN=0 is sampled and cnt=Nact-1.
REQ-014 STOP->IDLE on the wrap edge; Z SHALL end low and never show a shortened high or low phase.
REQ-015 If EN returns to 1 during STOP, the FSM SHALL go back to RUN with no change to cnt or Z, and the period SHALL continue seamlessly.
REQ-016 EN=1 sampled on the wrap edge in RUN SHALL start the next period with no gap, latching the new DIV.
REQ-017 Minimum ratio: DIV=0 (N=2) SHALL give Z toggling every CLK, with TC high on every Z-low cycle.
REQ-018 Maximum ratio: DIV=15 (N=17) SHALL give 9 high and 8 low cycles; cnt SHALL never exceed 16.

Reset
REQ-019 RST=1 sampled on a CLK edge SHALL force IDLE, cnt=0, Z=0, TC=0, BUSY=0, Nact=2 and H=1, overriding EN in every state, including mid-period.
REQ-020 While RST=1 the outputs SHALL stay at their reset values; on the first edge with RST=0 and EN=1 the block SHALL start per REQ-007.
REQ-021 RST SHALL take precedence over every simultaneous event.

Verification
REQ-022 DIV=2, EN=1 held for 20 cycles -> Z repeats 1,1,0,0; TC is high in every 4th cycle; BUSY=1.
REQ-023 DIV=1 (N=3), EN=1 -> Z repeats 1,1,0; TC is high on each Z-low cycle; the period is 3 CLK.
REQ-024 Running with DIV=6 (N=8), change DIV to 0 at cnt=2 -> the current period completes as 4 high and 4 low, then Z toggles every cycle.
REQ-025 N=8, EN dropped at cnt=1 -> Z stays high through cnt=3, is low for 4 cycles, then IDLE with BUSY=0 one cycle after TC.
REQ-026 N=8, EN dropped at cnt=5 and reasserted at cnt=6 -> no gap; the next period starts right after the wrap.
REQ-027 RST pulsed at cnt=2 of N=5 -> the next cycle shows Z=0, TC=0, BUSY=0; with EN still 1 after release, Z=1 one edge later.
